// File: rtl/fetch_stage_if.sv
// Bundle of the I-cache port and fetch/decode latch signals seen by the fetch stage.
// The master side is the fetch stage; the slave side is the cache plus pipeline.
interface fetch_stage_if;
  logic        iwait;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall_fd;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_fet;
  logic [31:0] pc4_fet;
  logic        fetch_valid;

  modport master (
    input  iwait, imemload, stall_fd, redirect_en, redirect_pc, halt,
    output iREN, imemaddr, instr_fet, pc4_fet, fetch_valid
  );

  modport slave (
    output iwait, imemload, stall_fd, redirect_en, redirect_pc, halt,
    input  iREN, imemaddr, instr_fet, pc4_fet, fetch_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, absorbs I-cache wait states, buffers one
// instruction across decode stalls, and handles redirects and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.master bus
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic [31:0] pc_plus4;
  logic        hit;

  assign pc_plus4 = pc_q + 32'd4;
  assign hit      = (state_q == FETCH) && !buf_valid_q && !bus.iwait;

  // While reset is held the outputs show the post-reset view, not stale state.
  always_comb begin
    bus.iREN        = 1'b0;
    bus.imemaddr    = pc_q;
    bus.fetch_valid = 1'b0;
    bus.instr_fet   = 32'h0;
    bus.pc4_fet     = pc_plus4;
    if (!nRST) begin
      bus.imemaddr = PC_INIT;
      bus.pc4_fet  = PC_INIT + 32'd4;
    end else begin
      case (state_q)
        FETCH: begin
          bus.iREN = !buf_valid_q;
          if (buf_valid_q) begin
            bus.fetch_valid = 1'b1;
            bus.instr_fet   = buf_instr_q;
            bus.pc4_fet     = buf_pc4_q;
          end else if (hit) begin
            bus.fetch_valid = 1'b1;
            bus.instr_fet   = bus.imemload;
          end
          if (bus.redirect_en) begin
            bus.fetch_valid = 1'b0;
          end
        end
        DRAIN: begin
          bus.iREN = 1'b1;
        end
        default: begin
          bus.iREN = 1'b0;
        end
      endcase
    end
  end

  // Halt outranks redirect, which outranks stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    if (bus.halt) begin
      state_d     = HALTED;
      buf_valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.redirect_en) begin
            buf_valid_d = 1'b0;
            if (bus.iwait) begin
              pend_pc_d = bus.redirect_pc;
              state_d   = DRAIN;
            end else begin
              pc_d = bus.redirect_pc;
            end
          end else if (buf_valid_q) begin
            if (!bus.stall_fd) begin
              buf_valid_d = 1'b0;
            end
          end else if (hit) begin
            pc_d = pc_plus4;
            if (bus.stall_fd) begin
              buf_valid_d = 1'b1;
              buf_instr_d = bus.imemload;
              buf_pc4_d   = pc_plus4;
            end
          end
        end
        DRAIN: begin
          if (bus.redirect_en) begin
            pend_pc_d = bus.redirect_pc;
          end
          if (!bus.iwait) begin
            pc_d    = bus.redirect_en ? bus.redirect_pc : pend_pc_q;
            state_d = FETCH;
          end
        end
        HALTED: begin
          buf_valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      pend_pc_q   <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of consumed instructions plus
// per-scenario checks of the cache-side and latch-side outputs.
module tb_fetch_stage;
  logic CLK = 1'b0;
  logic nRST;

  fetch_stage_if bus();

  fetch_stage #(.PC_INIT(32'h0000_0040)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbQ[$];
  logic [63:0] sbHead;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h40:  return 32'h0000_000A;
      32'h44:  return 32'h0000_000B;
      32'h48:  return 32'h0000_000C;
      default: return addr ^ 32'hDEAD_0000;
    endcase
  endfunction

  // Zero-latency cache model: data follows the address whenever a read is enabled.
  always_comb bus.imemload = bus.iREN ? memWord(bus.imemaddr) : 32'h0;

  // Every instruction the latch actually captures must match the next expected one.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && bus.fetch_valid === 1'b1 && bus.stall_fd === 1'b0) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected got instr=%h pc4=%h, expected none", bus.instr_fet, bus.pc4_fet);
      end else begin
        sbHead = sbQ.pop_front();
        if ({bus.instr_fet, bus.pc4_fet} !== sbHead) begin
          errors++;
          $display("[TB] FAIL sb_data got instr=%h pc4=%h, expected instr=%h pc4=%h",
                   bus.instr_fet, bus.pc4_fet, sbHead[63:32], sbHead[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectFetch(input logic [31:0] addr);
    sbQ.push_back({memWord(addr), addr + 32'd4});
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.iwait = 1'b0;
    bus.stall_fd = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.iREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_iREN got %b expected 0", bus.iREN); end
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.fetch_valid); end
    checks++;
    if (bus.instr_fet !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 0", bus.instr_fet); end
    checks++;
    if (bus.pc4_fet !== 32'h44) begin errors++; $display("[TB] FAIL reset_pc4 got %h expected 44", bus.pc4_fet); end
    checks++;
    if (bus.imemaddr !== 32'h40) begin errors++; $display("[TB] FAIL reset_addr got %h expected 40", bus.imemaddr); end
    nextCycle();
    nRST = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] addr;
      addr = 32'h40 + 32'(4 * i);
      bus.iwait = 1'b0;
      expectFetch(addr);
      @(negedge CLK);
      checks++;
      if (bus.imemaddr !== addr) begin errors++; $display("[TB] FAIL seq_addr got %h expected %h", bus.imemaddr, addr); end
      checks++;
      if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid got %b expected 1", bus.fetch_valid); end
      nextCycle();
    end
  endtask

  task automatic test_miss();
    bus.iwait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL miss_valid got %b expected 0", bus.fetch_valid); end
      checks++;
      if (bus.imemaddr !== 32'h4C || bus.iREN !== 1'b1) begin
        errors++; $display("[TB] FAIL miss_addr got addr=%h iREN=%b expected addr=4c iREN=1", bus.imemaddr, bus.iREN);
      end
      nextCycle();
    end
    bus.iwait = 1'b0;
    expectFetch(32'h4C);
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL miss_return got %b expected 1", bus.fetch_valid); end
    nextCycle();
  endtask

  task automatic test_stall();
    bus.iwait = 1'b0;
    bus.stall_fd = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.imemaddr !== 32'h50) begin
      errors++; $display("[TB] FAIL stall_hit got valid=%b addr=%h expected valid=1 addr=50", bus.fetch_valid, bus.imemaddr);
    end
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.iREN !== 1'b0) begin errors++; $display("[TB] FAIL stall_iREN got %b expected 0", bus.iREN); end
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.instr_fet !== memWord(32'h50) || bus.pc4_fet !== 32'h54) begin
      errors++; $display("[TB] FAIL stall_buffer got valid=%b instr=%h pc4=%h expected valid=1 instr=%h pc4=54",
                         bus.fetch_valid, bus.instr_fet, bus.pc4_fet, memWord(32'h50));
    end
    nextCycle();
    bus.stall_fd = 1'b0;
    expectFetch(32'h50);
    @(negedge CLK);
    checks++;
    if (bus.iREN !== 1'b0) begin errors++; $display("[TB] FAIL unstall_iREN got %b expected 0", bus.iREN); end
    nextCycle();
    expectFetch(32'h54);
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h54 || bus.fetch_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_fetch got addr=%h valid=%b expected addr=54 valid=1", bus.imemaddr, bus.fetch_valid);
    end
    nextCycle();
  endtask

  task automatic test_redirect_hit();
    bus.iwait = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush got %b expected 0", bus.fetch_valid); end
    nextCycle();
    bus.redirect_en = 1'b0;
    expectFetch(32'h100);
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h100 || bus.fetch_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL redir_target got addr=%h valid=%b expected addr=100 valid=1", bus.imemaddr, bus.fetch_valid);
    end
    nextCycle();
  endtask

  task automatic test_redirect_miss();
    bus.iwait = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_enter_valid got %b expected 0", bus.fetch_valid); end
    nextCycle();
    bus.redirect_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h104 || bus.iREN !== 1'b1 || bus.fetch_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_hold got addr=%h iREN=%b valid=%b expected addr=104 iREN=1 valid=0",
                         bus.imemaddr, bus.iREN, bus.fetch_valid);
    end
    nextCycle();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h300;
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h104) begin errors++; $display("[TB] FAIL drain_redir_addr got %h expected 104", bus.imemaddr); end
    nextCycle();
    bus.redirect_en = 1'b0;
    bus.iwait = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.imemaddr !== 32'h104) begin
      errors++; $display("[TB] FAIL drain_drop got valid=%b addr=%h expected valid=0 addr=104", bus.fetch_valid, bus.imemaddr);
    end
    nextCycle();
    expectFetch(32'h300);
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h300 || bus.fetch_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL drain_latest got addr=%h valid=%b expected addr=300 valid=1", bus.imemaddr, bus.fetch_valid);
    end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    bus.iwait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] addr;
      addr = 32'h304 + 32'(4 * i);
      expectFetch(addr);
      @(negedge CLK);
      checks++;
      if (bus.imemaddr !== addr || bus.fetch_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b got addr=%h valid=%b expected addr=%h valid=1", bus.imemaddr, bus.fetch_valid, addr);
      end
      nextCycle();
    end
  endtask

  task automatic test_halt();
    bus.halt = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h400;
    bus.iwait = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_cycle_valid got %b expected 0", bus.fetch_valid); end
    nextCycle();
    bus.halt = 1'b0;
    bus.redirect_pc = 32'h500;
    bus.iwait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.iREN !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.imemaddr !== 32'h314) begin
        errors++; $display("[TB] FAIL halted got iREN=%b valid=%b addr=%h expected iREN=0 valid=0 addr=314",
                           bus.iREN, bus.fetch_valid, bus.imemaddr);
      end
      nextCycle();
      bus.redirect_en = 1'b0;
    end
    bus.iwait = 1'b1;
    nRST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.iREN !== 1'b0 || bus.imemaddr !== 32'h40 || bus.pc4_fet !== 32'h44) begin
      errors++; $display("[TB] FAIL halt_reset got iREN=%b addr=%h pc4=%h expected iREN=0 addr=40 pc4=44",
                         bus.iREN, bus.imemaddr, bus.pc4_fet);
    end
    nextCycle();
    nRST = 1'b1;
    bus.iwait = 1'b0;
    expectFetch(32'h40);
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h40 || bus.fetch_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_restart got addr=%h valid=%b expected addr=40 valid=1", bus.imemaddr, bus.fetch_valid);
    end
    nextCycle();
  endtask

  task automatic test_reset_mid_drain();
    bus.iwait = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h600;
    nextCycle();
    bus.redirect_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.iREN !== 1'b1 || bus.imemaddr !== 32'h44) begin
      errors++; $display("[TB] FAIL drain2_hold got iREN=%b addr=%h expected iREN=1 addr=44", bus.iREN, bus.imemaddr);
    end
    nextCycle();
    nRST = 1'b0;
    nextCycle();
    nRST = 1'b1;
    bus.iwait = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] addr;
      addr = 32'h40 + 32'(4 * i);
      expectFetch(addr);
      @(negedge CLK);
      checks++;
      if (bus.imemaddr !== addr || bus.fetch_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL drain_reset got addr=%h valid=%b expected addr=%h valid=1", bus.imemaddr, bus.fetch_valid, addr);
      end
      nextCycle();
    end
  endtask

  task automatic test_scoreboard_empty();
    bus.iwait = 1'b1;
    repeat (2) nextCycle();
    checks++;
    if (sbQ.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover got %0d pending expected 0", sbQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_redirect_hit();
    test_redirect_miss();
    test_back_to_back();
    test_halt();
    test_reset_mid_drain();
    test_scoreboard_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
